// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute-stage controller.
// Optional feature macro: MULTI_SHIFT_EN (multi-iteration shifts, 1-4 per instruction).
package alu_pkg;

  // ALU select codes; the encoding is what the downstream ALU decodes
  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Bit positions inside the 4-bit FLAGS register
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Instruction field slices: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2/count-1
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two operand reads, one host read, host write port and
// a writeback port that wins over the host on an address collision.
module alu_regfile
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       wb_en_i,
  input  logic [1:0] wb_addr_i,
  input  logic [7:0] wb_data_i,
  input  logic [1:0] rs1_addr_i,
  input  logic [1:0] rs2_addr_i,
  input  logic [1:0] rd_addr_i,
  output logic [7:0] rs1_data_o,
  output logic [7:0] rs2_data_o,
  output logic [7:0] rd_data_o
);

  logic [3:0][7:0] regs_q;

  // Host write first, writeback second so the later NBA wins on collision
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else begin
      if (wr_en_i) regs_q[wr_addr_i] <= wr_data_i;
      if (wb_en_i) regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign rs1_data_o = regs_q[rs1_addr_i];
  assign rs2_data_o = regs_q[rs2_addr_i];
  assign rd_data_o  = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of a combinational 8-bit ALU.
// Accepts one instruction per handshake, holds operands for one EXEC cycle
// and writes the result and flags back on the following edge.
// Optional feature macro: MULTI_SHIFT_EN (shift count in INSTR[1:0] = count-1).
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic       WR_EN,
  input  logic [1:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic [1:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [1:0] ALU_SELECT,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  input  logic [7:0] ALU_RESULT,
  input  logic       CARRY,
  input  logic       OVERFLOW,
  input  logic       ZERO,
  input  logic       NEGATIVE,
  output logic [3:0] FLAGS,
  output logic       DONE
);

  state_e      state_q;
  logic [1:0]  sel_q;
  logic [7:0]  opa_q, opb_q;
  logic [1:0]  rd_q;
  logic [3:0]  flags_q;
  logic        done_q;
  logic [7:0]  rs1_data, rs2_data;
  logic        accept, wb_en;

`ifdef MULTI_SHIFT_EN
  logic [1:0]  cnt_q;   // remaining extra shift iterations
  assign wb_en = (state_q == EXEC) && (cnt_q == 2'd0);
`else
  assign wb_en = (state_q == EXEC);
`endif

  assign INSTR_READY = (state_q == IDLE) & ~RST;
  assign accept      = INSTR_VALID & INSTR_READY;

  alu_regfile u_rf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .wr_en_i    (WR_EN),
    .wr_addr_i  (WR_ADDR),
    .wr_data_i  (WR_DATA),
    .wb_en_i    (wb_en),
    .wb_addr_i  (rd_q),
    .wb_data_i  (ALU_RESULT),
    .rs1_addr_i (INSTR[RS1_HI:RS1_LO]),
    .rs2_addr_i (INSTR[RS2_HI:RS2_LO]),
    .rd_addr_i  (RD_ADDR),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .rd_data_o  (RD_DATA)
  );

  // Accept/EXEC control; reset aborts an in-flight instruction with no side effects
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= OP_SHL;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
`ifdef MULTI_SHIFT_EN
      cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sel_q   <= INSTR[OP_HI:OP_LO];
            opa_q   <= rs1_data;
            opb_q   <= rs2_data;
            rd_q    <= INSTR[RD_HI:RD_LO];
`ifdef MULTI_SHIFT_EN
            cnt_q   <= is_shift(INSTR[OP_HI:OP_LO]) ? INSTR[RS2_HI:RS2_LO] : 2'd0;
`endif
            state_q <= EXEC;
          end
        end
        EXEC: begin
`ifdef MULTI_SHIFT_EN
          if (cnt_q != 2'd0) begin
            opa_q <= ALU_RESULT;
            cnt_q <= cnt_q - 2'd1;
          end else
`endif
          begin
            flags_q[FLAG_C] <= CARRY;
            flags_q[FLAG_V] <= OVERFLOW;
            flags_q[FLAG_Z] <= ZERO;
            flags_q[FLAG_N] <= NEGATIVE;
            done_q          <= 1'b1;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ALU_SELECT = sel_q;
  assign ALU_A      = opa_q;
  assign ALU_B      = opb_q;
  assign FLAGS      = flags_q;
  assign DONE       = done_q;

endmodule
